// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg
// Shared types and constants for the Wishbone staging register.
// Holds the FSM state type, the default width parameters, and the widths
// of the watchdog counter and of the saturating timeout event counter.
package wb_stage_pkg;

  // Default widths and options used by the top-level parameters.
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TW      = 4;
  localparam int DEF_TMO_CYC = 255;
  localparam int DEF_REG_RSP = 1;

  // Cycle counter for the slave watchdog.
  localparam int TMO_CNT_W = 16;

  // Counter of timeout events reported to the outside.
  localparam int EVT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_wdog.sv
// wb_stage_wdog
// Slave watchdog for the staging register. It counts cycles spent waiting
// for the slave and flags the cycle on which the wait limit is reached.
// It also keeps a saturating count of the timeouts that were taken.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clr     - restart the cycle count (asserted when a request is captured)
//   run     - a waiting cycle with no slave response and no abort
//   expire  - the current waiting cycle is the last one allowed
//   evt_cnt - number of timeouts since reset, saturating at all ones
module wb_stage_wdog
  import wb_stage_pkg::*;
#(
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 run,
  output logic                 expire,
  output logic [EVT_CNT_W-1:0] evt_cnt
);

  // A zero limit disables the watchdog entirely.
  localparam bit WDOG_EN = (TMO_CYC != 0);
  localparam logic [TMO_CNT_W-1:0] LAST_CYC =
    WDOG_EN ? TMO_CNT_W'(TMO_CYC - 1) : '0;

  logic [TMO_CNT_W-1:0] wd_cnt;

  // Cycle counter: restarts when a request is captured and advances once
  // per waiting cycle. Wrapping is harmless, since with the watchdog
  // enabled the request leaves the wait state before the count can wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (clr) begin
      wd_cnt <= '0;
    end else if (run) begin
      wd_cnt <= wd_cnt + TMO_CNT_W'(1);
    end
  end

  // The count matches the limit minus one during the final allowed cycle,
  // so the error is presented the cycle after that.
  assign expire = WDOG_EN && (wd_cnt == LAST_CYC);

  // Timeout event counter. run already excludes cycles with a slave
  // response or an abort, so a response arriving on the expiry cycle
  // wins and is not counted here.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (run && expire && (evt_cnt != '1)) begin
      evt_cnt <= evt_cnt + EVT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe
// Wishbone staging register between an interconnect master port and a slow
// or remote slave. It registers one master request towards the slave and
// (optionally) registers the slave response back. Master aborts are
// handled, and a missing slave acknowledge is turned into a bus error by a
// watchdog.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   m_wbd_*_i               - request from the master (dat/adr/sel/we/cyc/stb/tid)
//   m_wbd_dat_o/ack_o/err_o - response to the master
//   s_wbd_dat_i/ack_i/err_i - response from the slave
//   s_wbd_*_o               - registered request to the slave
//   tmo_evt_o               - one-cycle pulse per timeout, aligned with its error
//   tmo_cnt_o               - timeouts since reset, saturating
// DW must be a multiple of 8.
module wb_stage_pipe
  import wb_stage_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TW      = DEF_TW,
  parameter int TMO_CYC = DEF_TMO_CYC,
  parameter int REG_RSP = DEF_REG_RSP
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DW-1:0]        m_wbd_dat_i,
  input  logic [AW-1:0]        m_wbd_adr_i,
  input  logic [DW/8-1:0]      m_wbd_sel_i,
  input  logic                 m_wbd_we_i,
  input  logic                 m_wbd_cyc_i,
  input  logic                 m_wbd_stb_i,
  input  logic [TW-1:0]        m_wbd_tid_i,
  output logic [DW-1:0]        m_wbd_dat_o,
  output logic                 m_wbd_ack_o,
  output logic                 m_wbd_err_o,
  input  logic [DW-1:0]        s_wbd_dat_i,
  input  logic                 s_wbd_ack_i,
  input  logic                 s_wbd_err_i,
  output logic [DW-1:0]        s_wbd_dat_o,
  output logic [AW-1:0]        s_wbd_adr_o,
  output logic [DW/8-1:0]      s_wbd_sel_o,
  output logic                 s_wbd_we_o,
  output logic                 s_wbd_cyc_o,
  output logic                 s_wbd_stb_o,
  output logic [TW-1:0]        s_wbd_tid_o,
  output logic                 tmo_evt_o,
  output logic [EVT_CNT_W-1:0] tmo_cnt_o
);

  localparam bit REG_EN = (REG_RSP != 0);

  wb_state_e state;
  wb_state_e state_nxt;

  logic [DW-1:0]   req_dat;
  logic [AW-1:0]   req_adr;
  logic [DW/8-1:0] req_sel;
  logic            req_we;
  logic [TW-1:0]   req_tid;

  logic            rsp_ack_q;
  logic            rsp_err_q;
  logic [DW-1:0]   rsp_dat_q;
  logic            evt_q;

  logic capture;
  logic in_req;
  logic abort;
  logic take_err;
  logic take_ack;
  logic wd_run;
  logic wd_expire;
  logic take_tmo;
  logic rsp_exit;

  // Exit conditions out of REQ, already in priority order: abort beats
  // error, error beats ack, and any slave response beats the watchdog.
  assign capture  = (state == IDLE) && m_wbd_cyc_i && m_wbd_stb_i;
  assign in_req   = (state == REQ);
  assign abort    = in_req && !m_wbd_cyc_i;
  assign take_err = in_req && m_wbd_cyc_i && s_wbd_err_i;
  assign take_ack = in_req && m_wbd_cyc_i && !s_wbd_err_i && s_wbd_ack_i;
  assign wd_run   = in_req && m_wbd_cyc_i && !s_wbd_err_i && !s_wbd_ack_i;
  assign take_tmo = wd_run && wd_expire;
  assign rsp_exit = take_err || take_ack || take_tmo;

  wb_stage_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (capture),
    .run     (wd_run),
    .expire  (wd_expire),
    .evt_cnt (tmo_cnt_o)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A timeout always goes through RSP because its error
  // is registered even when slave responses are passed straight through.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (take_tmo) begin
          state_nxt = RSP;
        end else if (take_err || take_ack) begin
          state_nxt = REG_EN ? RSP : IDLE;
        end
      end
      RSP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request holding registers: loaded on capture, held stable through REQ,
  // and cleared as soon as the transaction leaves REQ for any reason.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_dat <= '0;
      req_adr <= '0;
      req_sel <= '0;
      req_we  <= 1'b0;
      req_tid <= '0;
    end else if (capture) begin
      req_dat <= m_wbd_dat_i;
      req_adr <= m_wbd_adr_i;
      req_sel <= m_wbd_sel_i;
      req_we  <= m_wbd_we_i;
      req_tid <= m_wbd_tid_i;
    end else if (abort || rsp_exit) begin
      req_dat <= '0;
      req_adr <= '0;
      req_sel <= '0;
      req_we  <= 1'b0;
      req_tid <= '0;
    end
  end

  // Registered response. These flops are only ever set on the edge that
  // moves REQ into RSP, so they are high for exactly the one RSP cycle.
  // Read data is kept only for an ack; a timeout error carries zero data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_ack_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
      evt_q     <= 1'b0;
    end else begin
      rsp_ack_q <= REG_EN && take_ack;
      rsp_err_q <= (REG_EN && take_err) || take_tmo;
      rsp_dat_q <= (REG_EN && take_ack) ? s_wbd_dat_i : '0;
      evt_q     <= take_tmo;
    end
  end

  // Output decode. The slave strobe and cycle are a decode of the state
  // register. With the combinational response option, slave ack/err pass
  // through during REQ, gated by the master cycle, so an abort suppresses
  // them; the registered flops then only ever carry timeout errors.
  always_comb begin
    s_wbd_cyc_o = in_req;
    s_wbd_stb_o = in_req;
    s_wbd_dat_o = req_dat;
    s_wbd_adr_o = req_adr;
    s_wbd_sel_o = req_sel;
    s_wbd_we_o  = req_we;
    s_wbd_tid_o = req_tid;
    tmo_evt_o   = evt_q;
    m_wbd_ack_o = rsp_ack_q;
    m_wbd_err_o = rsp_err_q;
    m_wbd_dat_o = rsp_dat_q;
    if (!REG_EN) begin
      m_wbd_ack_o = rsp_ack_q || take_ack;
      m_wbd_err_o = rsp_err_q || take_err;
      if (take_ack) begin
        m_wbd_dat_o = s_wbd_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe
// Directed bench for wb_stage_pipe. Two instances share the stimulus: one
// with a registered response path and one with a combinational response
// path, both with an 8-cycle watchdog. The combinational instance is only
// checked after a common reset in the final section.
module tb_wb_stage_pipe;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] m_dat_i;
  logic [AW-1:0] m_adr_i;
  logic [3:0]    m_sel_i;
  logic          m_we_i, m_cyc_i, m_stb_i;
  logic [TW-1:0] m_tid_i;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i;

  // Outputs of the registered-response instance.
  logic [DW-1:0] r_m_dat, r_s_dat;
  logic          r_m_ack, r_m_err;
  logic [AW-1:0] r_s_adr;
  logic [3:0]    r_s_sel;
  logic          r_s_we, r_s_cyc, r_s_stb;
  logic [TW-1:0] r_s_tid;
  logic          r_evt;
  logic [7:0]    r_cnt;

  // Outputs of the combinational-response instance.
  logic [DW-1:0] c_m_dat, c_s_dat;
  logic          c_m_ack, c_m_err;
  logic [AW-1:0] c_s_adr;
  logic [3:0]    c_s_sel;
  logic          c_s_we, c_s_cyc, c_s_stb;
  logic [TW-1:0] c_s_tid;
  logic          c_evt;
  logic [7:0]    c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_stage_pipe #(
    .AW(AW), .DW(DW), .TW(TW), .TMO_CYC(TMO), .REG_RSP(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_wbd_dat_i(m_dat_i), .m_wbd_adr_i(m_adr_i), .m_wbd_sel_i(m_sel_i),
    .m_wbd_we_i(m_we_i), .m_wbd_cyc_i(m_cyc_i), .m_wbd_stb_i(m_stb_i),
    .m_wbd_tid_i(m_tid_i),
    .m_wbd_dat_o(r_m_dat), .m_wbd_ack_o(r_m_ack), .m_wbd_err_o(r_m_err),
    .s_wbd_dat_i(s_dat_i), .s_wbd_ack_i(s_ack_i), .s_wbd_err_i(s_err_i),
    .s_wbd_dat_o(r_s_dat), .s_wbd_adr_o(r_s_adr), .s_wbd_sel_o(r_s_sel),
    .s_wbd_we_o(r_s_we), .s_wbd_cyc_o(r_s_cyc), .s_wbd_stb_o(r_s_stb),
    .s_wbd_tid_o(r_s_tid),
    .tmo_evt_o(r_evt), .tmo_cnt_o(r_cnt)
  );

  wb_stage_pipe #(
    .AW(AW), .DW(DW), .TW(TW), .TMO_CYC(TMO), .REG_RSP(0)
  ) dut_c (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_wbd_dat_i(m_dat_i), .m_wbd_adr_i(m_adr_i), .m_wbd_sel_i(m_sel_i),
    .m_wbd_we_i(m_we_i), .m_wbd_cyc_i(m_cyc_i), .m_wbd_stb_i(m_stb_i),
    .m_wbd_tid_i(m_tid_i),
    .m_wbd_dat_o(c_m_dat), .m_wbd_ack_o(c_m_ack), .m_wbd_err_o(c_m_err),
    .s_wbd_dat_i(s_dat_i), .s_wbd_ack_i(s_ack_i), .s_wbd_err_i(s_err_i),
    .s_wbd_dat_o(c_s_dat), .s_wbd_adr_o(c_s_adr), .s_wbd_sel_o(c_s_sel),
    .s_wbd_we_o(c_s_we), .s_wbd_cyc_o(c_s_cyc), .s_wbd_stb_o(c_s_stb),
    .s_wbd_tid_o(c_s_tid),
    .tmo_evt_o(c_evt), .tmo_cnt_o(c_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [3:0] tid);
    m_cyc_i = cyc;
    m_stb_i = stb;
    m_we_i  = we;
    m_adr_i = adr;
    m_dat_i = dat;
    m_sel_i = sel;
    m_tid_i = tid;
  endtask

  task automatic slaveDrive(input logic ack, input logic err, input logic [31:0] dat);
    s_ack_i = ack;
    s_err_i = err;
    s_dat_i = dat;
  endtask

  task automatic masterIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
  endtask

  // One full timeout transaction with a silent slave, ending back in IDLE.
  task automatic runTimeout();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'h7);
    tick();
    repeat (TMO) tick();
    masterIdle();
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    masterIdle();
    slaveDrive(1'b0, 1'b0, 32'h0);
    repeat (3) tick();

    // Reset state.
    checkOutput("rst_m_ack", r_m_ack, 0);
    checkOutput("rst_m_err", r_m_err, 0);
    checkOutput("rst_m_dat", r_m_dat, 0);
    checkOutput("rst_s_stb", r_s_stb, 0);
    checkOutput("rst_s_cyc", r_s_cyc, 0);
    checkOutput("rst_tmo_cnt", r_cnt, 0);
    rst_i = 1'b0;
    tick();

    // Read with slave acking two cycles into REQ.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h1000_0040, 32'h0, 4'hF, 4'h3);
    tick();
    checkOutput("rd_s_stb", r_s_stb, 1);
    checkOutput("rd_s_cyc", r_s_cyc, 1);
    checkOutput("rd_s_adr", r_s_adr, 32'h1000_0040);
    checkOutput("rd_s_tid", r_s_tid, 3);
    checkOutput("rd_s_we", r_s_we, 0);
    tick();
    checkOutput("rd_s_adr_hold1", r_s_adr, 32'h1000_0040);
    checkOutput("rd_m_ack_early", r_m_ack, 0);
    tick();
    checkOutput("rd_s_adr_hold2", r_s_adr, 32'h1000_0040);
    checkOutput("rd_s_tid_hold2", r_s_tid, 3);
    slaveDrive(1'b1, 1'b0, 32'hA5A5_0001);
    tick();
    checkOutput("rd_m_ack", r_m_ack, 1);
    checkOutput("rd_m_dat", r_m_dat, 32'hA5A5_0001);
    checkOutput("rd_m_err", r_m_err, 0);
    checkOutput("rd_s_stb_off", r_s_stb, 0);
    checkOutput("rd_s_adr_clr", r_s_adr, 0);
    masterIdle();
    slaveDrive(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rd_m_ack_1cyc", r_m_ack, 0);
    checkOutput("rd_m_dat_zero", r_m_dat, 0);

    // Write, then read presented the cycle after the ack.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'b0011, 4'h5);
    tick();
    checkOutput("wr_s_we", r_s_we, 1);
    checkOutput("wr_s_dat", r_s_dat, 32'hDEAD_BEEF);
    checkOutput("wr_s_sel", r_s_sel, 4'b0011);
    checkOutput("wr_s_tid", r_s_tid, 5);
    slaveDrive(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("wr_m_ack", r_m_ack, 1);
    checkOutput("wr_s_cyc_off", r_s_cyc, 0);
    slaveDrive(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'hF, 4'h6);
    tick();
    checkOutput("b2b_gap_s_cyc", r_s_cyc, 0);
    checkOutput("b2b_gap_m_ack", r_m_ack, 0);
    tick();
    checkOutput("b2b_rd_s_cyc", r_s_cyc, 1);
    checkOutput("b2b_rd_s_adr", r_s_adr, 32'h2000_0004);
    checkOutput("b2b_rd_s_we", r_s_we, 0);
    checkOutput("b2b_rd_s_tid", r_s_tid, 6);
    slaveDrive(1'b1, 1'b0, 32'h1234_5678);
    tick();
    checkOutput("b2b_rd_m_ack", r_m_ack, 1);
    checkOutput("b2b_rd_m_dat", r_m_dat, 32'h1234_5678);
    masterIdle();
    slaveDrive(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("b2b_no_dup1", r_s_stb, 0);
    tick();
    checkOutput("b2b_no_dup2", r_s_stb, 0);

    // Timeout with a silent slave; junk read data must not leak out.
    slaveDrive(1'b0, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'h7);
    tick();
    repeat (TMO - 1) tick();
    checkOutput("tmo_pre_err", r_m_err, 0);
    checkOutput("tmo_pre_stb", r_s_stb, 1);
    checkOutput("tmo_pre_evt", r_evt, 0);
    tick();
    checkOutput("tmo_m_err", r_m_err, 1);
    checkOutput("tmo_m_ack", r_m_ack, 0);
    checkOutput("tmo_m_dat", r_m_dat, 0);
    checkOutput("tmo_evt", r_evt, 1);
    checkOutput("tmo_cnt1", r_cnt, 1);
    masterIdle();
    slaveDrive(1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    checkOutput("tmo_err_1cyc", r_m_err, 0);
    checkOutput("tmo_evt_1cyc", r_evt, 0);
    checkOutput("late_ack_m_ack", r_m_ack, 0);
    tick();
    checkOutput("late_ack_m_ack2", r_m_ack, 0);
    checkOutput("late_ack_s_stb", r_s_stb, 0);
    checkOutput("tmo_cnt_hold", r_cnt, 1);
    slaveDrive(1'b0, 1'b0, 32'h0);

    // Simultaneous ack and err: error wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0100, 32'h0, 4'hF, 4'h1);
    tick();
    slaveDrive(1'b1, 1'b1, 32'h0000_0055);
    tick();
    checkOutput("ackerr_m_err", r_m_err, 1);
    checkOutput("ackerr_m_ack", r_m_ack, 0);
    checkOutput("ackerr_m_dat", r_m_dat, 0);
    masterIdle();
    slaveDrive(1'b0, 1'b0, 32'h0);
    tick();

    // Ack on the exact expiry cycle: ack wins, no timeout event.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'h2);
    tick();
    repeat (TMO - 1) tick();
    slaveDrive(1'b1, 1'b0, 32'hCAFE_0008);
    tick();
    checkOutput("expack_m_ack", r_m_ack, 1);
    checkOutput("expack_m_err", r_m_err, 0);
    checkOutput("expack_m_dat", r_m_dat, 32'hCAFE_0008);
    checkOutput("expack_evt", r_evt, 0);
    checkOutput("expack_cnt", r_cnt, 1);
    masterIdle();
    slaveDrive(1'b0, 1'b0, 32'h0);
    tick();

    // Master abort while the slave acks in the same cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0300, 32'h0, 4'hF, 4'h4);
    tick();
    tick();
    masterIdle();
    slaveDrive(1'b1, 1'b0, 32'h0000_0077);
    tick();
    checkOutput("abort_m_ack", r_m_ack, 0);
    checkOutput("abort_m_err", r_m_err, 0);
    checkOutput("abort_s_cyc", r_s_cyc, 0);
    checkOutput("abort_s_adr", r_s_adr, 0);
    slaveDrive(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("abort_no_rsp", r_m_ack, 0);

    // Saturation of the timeout counter (300 timeouts in total).
    for (int i = 0; i < 253; i++) runTimeout();
    checkOutput("tmo_cnt_254", r_cnt, 254);
    for (int i = 0; i < 46; i++) runTimeout();
    checkOutput("tmo_cnt_sat", r_cnt, 255);

    // Reset in the middle of a request.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h5000_0010, 32'h0000_1111, 4'hF, 4'hA);
    tick();
    checkOutput("midrst_pre_stb", r_s_stb, 1);
    rst_i = 1'b1;
    tick();
    checkOutput("midrst_s_stb", r_s_stb, 0);
    checkOutput("midrst_s_cyc", r_s_cyc, 0);
    checkOutput("midrst_s_adr", r_s_adr, 0);
    checkOutput("midrst_s_dat", r_s_dat, 0);
    checkOutput("midrst_s_tid", r_s_tid, 0);
    checkOutput("midrst_s_we", r_s_we, 0);
    checkOutput("midrst_s_sel", r_s_sel, 0);
    checkOutput("midrst_m_ack", r_m_ack, 0);
    checkOutput("midrst_m_err", r_m_err, 0);
    checkOutput("midrst_tmo_cnt", r_cnt, 0);
    rst_i = 1'b0;
    masterIdle();
    tick();
    checkOutput("midrst_after_stb", r_s_stb, 0);

    // Combinational response path: ack and data in the same cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 4'h9);
    tick();
    checkOutput("c_s_stb", c_s_stb, 1);
    checkOutput("c_s_adr", c_s_adr, 32'h4000_0000);
    slaveDrive(1'b1, 1'b0, 32'h0BAD_F00D);
    #1;
    checkOutput("c_m_ack_comb", c_m_ack, 1);
    checkOutput("c_m_dat_comb", c_m_dat, 32'h0BAD_F00D);
    checkOutput("c_m_err_comb", c_m_err, 0);
    checkOutput("r_m_ack_not_yet", r_m_ack, 0);
    tick();
    masterIdle();
    slaveDrive(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("c_after_ack", c_m_ack, 0);
    checkOutput("c_after_stb", c_s_stb, 0);
    checkOutput("r_reg_ack", r_m_ack, 1);
    checkOutput("r_reg_dat", r_m_dat, 32'h0BAD_F00D);
    tick();

    // Combinational path is gated by the master cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000_0004, 32'h0, 4'hF, 4'h8);
    tick();
    masterIdle();
    slaveDrive(1'b1, 1'b0, 32'h0000_00AA);
    #1;
    checkOutput("c_abort_ack", c_m_ack, 0);
    checkOutput("c_abort_dat", c_m_dat, 0);
    tick();
    slaveDrive(1'b0, 1'b0, 32'h0);
    tick();

    // Timeout on the combinational instance is still registered.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'hF, 4'hB);
    tick();
    repeat (TMO - 1) tick();
    checkOutput("c_tmo_pre_err", c_m_err, 0);
    tick();
    checkOutput("c_tmo_err", c_m_err, 1);
    checkOutput("c_tmo_evt", c_evt, 1);
    checkOutput("c_tmo_cnt", c_cnt, 1);
    checkOutput("c_tmo_dat", c_m_dat, 0);
    masterIdle();
    tick();
    checkOutput("c_tmo_err_1cyc", c_m_err, 0);
    checkOutput("c_tmo_evt_1cyc", c_evt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
